fifo_s1_flags: RTL and testbench

//  Single-clock synchronous FIFO with a full status-flag set (empty, almost-empty, half-full,

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_s1_ram.sv | 24 ++
 rtl/fifo_s1_flags.sv | 122 ++++++++++++
 tb/tb_fifo_s1_flags.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock flagged FIFO.
package fifo_pkg;

  typedef enum logic {
    ERR_STICKY  = 1'b0,
    ERR_DYNAMIC = 1'b1
  } err_mode_e;

  // Width needed to hold a count from 0 up to and including depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_s1_ram.sv
// DEPTH x DATA_WIDTH storage: synchronous write, asynchronous (show-ahead) read.
module fifo_s1_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_s1_flags.sv
// Single-clock FIFO with registered status flags, word count and selectable error mode.
module fifo_s1_flags
  import fifo_pkg::*;
#(
  parameter int        DATA_WIDTH = 32,
  parameter int        DEPTH      = 8,
  parameter int        AE_LEVEL   = 1,
  parameter int        AF_LEVEL   = 1,
  parameter err_mode_e ERR_MODE   = ERR_STICKY,
  localparam int       CW         = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_req_n,
  input  logic                  pop_req_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CW-1:0]         word_count,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  half_full,
  output logic                  almost_full,
  output logic                  full,
  output logic                  error
);

  localparam int          PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);
  localparam logic [CW-1:0] HF_CNT   = CW'((DEPTH + 1) / 2);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_LEVEL);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
    $error("fifo_s1_flags: DATA_WIDTH out of range");
  end
  if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $error("fifo_s1_flags: DEPTH out of range");
  end
  if (AE_LEVEL < 1 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_s1_flags: AE_LEVEL out of range");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
    $error("fifo_s1_flags: AF_LEVEL out of range");
  end

  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_empty, r_aempty, r_half, r_afull, r_full, r_error;
  logic                  w_push_ok, w_pop_ok, w_viol;
  logic [CW-1:0]         w_next_count;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a paired push.
  assign w_pop_ok  = !pop_req_n && !r_empty;
  assign w_push_ok = !push_req_n && (!r_full || w_pop_ok);
  assign w_viol    = (!push_req_n && r_full && !w_pop_ok) || (!pop_req_n && r_empty);

  // Next occupancy; flags are derived from this so they move with word_count.
  always_comb begin
    w_next_count = r_count;
    if (w_push_ok && !w_pop_ok) w_next_count = r_count + CW'(1);
    else if (w_pop_ok && !w_push_ok) w_next_count = r_count - CW'(1);
  end

  // Pointers, count and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_aempty <= 1'b1;
      r_half   <= 1'b0;
      r_afull  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
      r_count  <= w_next_count;
      r_empty  <= (w_next_count == '0);
      r_aempty <= (w_next_count <= AE_CNT);
      r_half   <= (w_next_count >= HF_CNT);
      r_afull  <= (w_next_count >= AF_CNT);
      r_full   <= (w_next_count == CNT_MAX);
    end
  end

  // Error: latched until reset in sticky mode, one-cycle echo of the violation otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_error <= 1'b0;
    else if (ERR_MODE == ERR_DYNAMIC) r_error <= w_viol;
    else r_error <= r_error | w_viol;
  end

  fifo_s1_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_ram (
    .clk       (clk),
    .i_wr_en   (w_push_ok),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign data_out     = r_empty ? '0 : w_rd_data;
  assign word_count   = r_count;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign half_full    = r_half;
  assign almost_full  = r_afull;
  assign full         = r_full;
  assign error        = r_error;

  // Requests must be known whenever the FIFO is out of reset.
  a_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({push_req_n, pop_req_n}));

endmodule

// File: tb/tb_fifo_s1_flags.sv
// Bench: two FIFOs (DEPTH 8 sticky, DEPTH 6 dynamic) share one stimulus stream and
// are checked every cycle against a queue model, plus literal spot checks.
module tb_fifo_s1_flags;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       push_n = 1'b1;
  logic       pop_n = 1'b1;
  logic [7:0] din = 8'h00;

  logic [7:0] d8_out, d6_out;
  logic [3:0] wc8;
  logic [2:0] wc6;
  logic e8, ae8, hf8, af8, f8, er8;
  logic e6, ae6, hf6, af6, f6, er6;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fifo_s1_flags #(
    .DATA_WIDTH (8), .DEPTH (8), .AE_LEVEL (1), .AF_LEVEL (1),
    .ERR_MODE (fifo_pkg::ERR_STICKY)
  ) u8 (
    .clk (clk), .rst_n (rst_n), .push_req_n (push_n), .pop_req_n (pop_n),
    .data_in (din), .data_out (d8_out), .word_count (wc8), .empty (e8),
    .almost_empty (ae8), .half_full (hf8), .almost_full (af8), .full (f8), .error (er8)
  );

  fifo_s1_flags #(
    .DATA_WIDTH (8), .DEPTH (6), .AE_LEVEL (2), .AF_LEVEL (2),
    .ERR_MODE (fifo_pkg::ERR_DYNAMIC)
  ) u6 (
    .clk (clk), .rst_n (rst_n), .push_req_n (push_n), .pop_req_n (pop_n),
    .data_in (din), .data_out (d6_out), .word_count (wc6), .empty (e6),
    .almost_empty (ae6), .half_full (hf6), .almost_full (af6), .full (f6), .error (er6)
  );

  // Model configuration: index 0 = u8, index 1 = u6.
  int MD[2]   = '{8, 6};
  int MAE[2]  = '{1, 2};
  int MAF[2]  = '{1, 2};
  bit MDYN[2] = '{1'b0, 1'b1};

  logic [7:0] mq[2][$];
  bit         merr[2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue model of the FIFO behaviour.
  always @(posedge clk or negedge rst_n) begin
    int c;
    bit pu, po, pop_ok, push_ok, viol;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        merr[k] = 1'b0;
      end else begin
        c       = mq[k].size();
        pu      = !push_n;
        po      = !pop_n;
        pop_ok  = po && (c > 0);
        push_ok = pu && ((c < MD[k]) || pop_ok);
        viol    = (pu && (c == MD[k]) && !pop_ok) || (po && (c == 0));
        if (pop_ok) void'(mq[k].pop_front());
        if (push_ok) mq[k].push_back(din);
        merr[k] = MDYN[k] ? viol : (merr[k] | viol);
      end
    end
  end

  // Per-cycle comparison against the model, sampled after the edge settles.
  always @(posedge clk) begin
    int c, a_dout, a_wc;
    bit a_e, a_ae, a_hf, a_af, a_f, a_er;
    string tag;
    #2;
    for (int k = 0; k < 2; k++) begin
      c   = mq[k].size();
      tag = (k == 0) ? "u8" : "u6";
      if (k == 0) begin
        a_dout = d8_out; a_wc = wc8; a_e = e8; a_ae = ae8; a_hf = hf8; a_af = af8; a_f = f8; a_er = er8;
      end else begin
        a_dout = d6_out; a_wc = wc6; a_e = e6; a_ae = ae6; a_hf = hf6; a_af = af6; a_f = f6; a_er = er6;
      end
      chk({tag, ".word_count"},   a_wc,   c);
      chk({tag, ".data_out"},     a_dout, (c > 0) ? int'(mq[k][0]) : 0);
      chk({tag, ".empty"},        a_e,    int'(c == 0));
      chk({tag, ".almost_empty"}, a_ae,   int'(c <= MAE[k]));
      chk({tag, ".half_full"},    a_hf,   int'(c >= (MD[k] + 1) / 2));
      chk({tag, ".almost_full"},  a_af,   int'(c >= MD[k] - MAF[k]));
      chk({tag, ".full"},         a_f,    int'(c == MD[k]));
      chk({tag, ".error"},        a_er,   int'(merr[k]));
    end
  end

  task automatic cyc(input bit p, input bit q, input logic [7:0] d);
    push_n = !p;
    pop_n  = !q;
    din    = d;
    @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk("rst.u8.empty", e8, 1);        chk("rst.u8.almost_empty", ae8, 1);
    chk("rst.u8.half_full", hf8, 0);   chk("rst.u8.almost_full", af8, 0);
    chk("rst.u8.full", f8, 0);         chk("rst.u8.error", er8, 0);
    chk("rst.u8.word_count", wc8, 0);  chk("rst.u8.data_out", d8_out, 0);
    chk("rst.u6.empty", e6, 1);        chk("rst.u6.word_count", wc6, 0);
    chk("rst.u6.error", er6, 0);       chk("rst.u6.data_out", d6_out, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_values();
    rst_n = 1'b1;

    // Fill DEPTH 8 with 1..8 and watch each flag threshold.
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 8'(i));
      chk("fill.u8.word_count", wc8, i);
      chk("fill.u8.almost_empty", ae8, int'(i <= 1));
      chk("fill.u8.half_full", hf8, int'(i >= 4));
      chk("fill.u8.almost_full", af8, int'(i >= 7));
      chk("fill.u8.full", f8, int'(i == 8));
      chk("fill.u8.data_out", d8_out, 1);
    end
    for (int i = 1; i <= 8; i++) begin
      chk("drain.u8.data_out", d8_out, i);
      cyc(0, 1, 8'h00);
    end
    chk("drain.u8.empty", e8, 1);
    chk("drain.u8.error", er8, 0);

    // Interleaved traffic with pointer wrap.
    cyc(0, 0, 8'h00);
    for (int i = 0; i < 20; i++) cyc((i % 4) != 3, (i % 2) == 1, 8'(8'h10 + i));
    chk("mix.u8.word_count", wc8, 5);
    chk("mix.u6.word_count", wc6, 5);
    chk("mix.u8.error", er8, 0);
    chk("mix.u6.error", er6, 0);

    // Full plus simultaneous push/pop.
    cyc(1, 0, 8'h40);
    chk("full.u6.full", f6, 1);
    cyc(1, 1, 8'h41);
    chk("fullpp.u6.word_count", wc6, 6);
    chk("fullpp.u6.error", er6, 0);
    chk("fullpp.u6.full", f6, 1);

    // Drain, then underflow: sticky on u8, pulse on u6.
    repeat (6) cyc(0, 1, 8'h00);
    chk("uflow.pre.u8.error", er8, 0);
    cyc(0, 1, 8'h00);
    chk("uflow.u8.error", er8, 1);
    chk("uflow.u6.error", er6, 1);
    chk("uflow.u8.word_count", wc8, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'h50 + i));
    chk("sticky.u8.error", er8, 1);
    chk("sticky.u6.error", er6, 0);
    chk("sticky.u6.full", f6, 1);
    cyc(1, 0, 8'h56);
    chk("oflow.u6.error", er6, 1);
    chk("oflow.u6.word_count", wc6, 6);
    chk("oflow.u8.word_count", wc8, 7);
    cyc(0, 0, 8'h00);
    chk("oflow.after.u6.error", er6, 0);

    // Reset in the middle of a burst.
    cyc(0, 1, 8'h00);
    cyc(0, 1, 8'h00);
    chk("prerst.u8.word_count", wc8, 5);
    push_n = 1'b0;
    din    = 8'h60;
    #2 rst_n = 1'b0;
    #1 chk_reset_values();
    @(negedge clk);
    push_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 0, 8'h70);
    cyc(1, 0, 8'h71);
    cyc(1, 0, 8'h72);
    cyc(0, 0, 8'h00);
    chk("refill.u8.word_count", wc8, 3);
    chk("refill.u8.data_out", d8_out, 8'h70);
    chk("refill.u6.word_count", wc6, 3);
    chk("refill.u8.error", er8, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
